// File: rtl/cam_pkg.sv
// Shared types and default geometry for the camera frame-capture sequencer.
package cam_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitBlank,
        StWaitFrame,
        StCapture,
        StDone
    } cam_state_e;

    localparam int unsigned H_PIX_DEF   = 160;
    localparam int unsigned V_LINES_DEF = 120;
    localparam int unsigned ADDR_W_DEF  = 15;
    localparam int unsigned FRAME_PIX   = H_PIX_DEF * V_LINES_DEF;

    function automatic int unsigned frame_pix(input int unsigned h, input int unsigned v);
        return h * v;
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Registers one camera control bit and flags its rising and falling edges.
module cam_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic level_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            level_q <= d_i;
            prev_q  <= level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~prev_q;
    assign fall_o  = ~level_q & prev_q;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer: arms on start, aligns to Vsync, gates packer writes into the buffer.
// Build option CAM_LINE_CHECK_EN adds a sticky err_line output for per-line pixel count checks.
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int unsigned H_PIX   = H_PIX_DEF,
    parameter int unsigned V_LINES = V_LINES_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
    input  logic              Pclk,
    input  logic              rst,
    input  logic              Vsync,
    input  logic              Href,
    input  logic              start,
    input  logic              continuous,
    input  logic              stop,
    input  logic              pix_wr,
    output logic              pix_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic              err_short,
`ifdef CAM_LINE_CHECK_EN
    output logic              err_line,
`endif
    output logic [7:0]        line_cnt
);

    localparam int unsigned FramePix = frame_pix(H_PIX, V_LINES);
    localparam int unsigned CntW     = ADDR_W + 1;

    cam_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        line_cnt_q;
    logic              pix_en_q, mem_we_q, done_q, err_ovf_q, err_short_q;

    logic vs_level, vs_rise, vs_fall;
    logic href_level, href_rise, href_fall;

    cam_sync_edge u_vsync (
        .clk_i   (Pclk),
        .rst_i   (rst),
        .d_i     (Vsync),
        .level_o (vs_level),
        .rise_o  (vs_rise),
        .fall_o  (vs_fall)
    );

    cam_sync_edge u_href (
        .clk_i   (Pclk),
        .rst_i   (rst),
        .d_i     (Href),
        .level_o (href_level),
        .rise_o  (href_rise),
        .fall_o  (href_fall)
    );

    // Pixels accepted so far, including a write whose address bump is still pending.
    logic [CntW-1:0] pix_cnt;
    logic            frame_full;
    assign pix_cnt    = {1'b0, addr_q} + CntW'(mem_we_q);
    assign frame_full = pix_cnt >= CntW'(FramePix);

    always_ff @(posedge Pclk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            line_cnt_q  <= '0;
            pix_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            done_q      <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_short_q <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            if (mem_we_q) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            if (stop) begin
                state_q  <= StIdle;
                pix_en_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            state_q     <= StWaitBlank;
                            addr_q      <= '0;
                            line_cnt_q  <= '0;
                            err_ovf_q   <= 1'b0;
                            err_short_q <= 1'b0;
                        end
                    end
                    StWaitBlank: begin
                        if (vs_level) begin
                            state_q <= StWaitFrame;
                        end
                    end
                    StWaitFrame: begin
                        if (vs_fall) begin
                            state_q  <= StCapture;
                            pix_en_q <= 1'b1;
                        end
                    end
                    StCapture: begin
                        if (vs_rise) begin
                            state_q  <= StDone;
                            pix_en_q <= 1'b0;
                            done_q   <= 1'b1;
                            if (!frame_full) begin
                                err_short_q <= 1'b1;
                            end
                        end else begin
                            if (pix_wr) begin
                                if (frame_full) begin
                                    err_ovf_q <= 1'b1;
                                end else begin
                                    mem_we_q <= 1'b1;
                                end
                            end
                            if (href_fall && (line_cnt_q < 8'(V_LINES))) begin
                                line_cnt_q <= line_cnt_q + 8'd1;
                            end
                        end
                    end
                    StDone: begin
                        if (continuous) begin
                            state_q    <= StWaitFrame;
                            addr_q     <= '0;
                            line_cnt_q <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef CAM_LINE_CHECK_EN
    // pix_wr is delayed one cycle so it lines up with the registered Href edges.
    logic        pix_wr_q;
    logic [15:0] line_pix_q;
    logic        err_line_q;

    always_ff @(posedge Pclk) begin
        if (rst) begin
            pix_wr_q   <= 1'b0;
            line_pix_q <= '0;
            err_line_q <= 1'b0;
        end else begin
            pix_wr_q <= pix_wr;
            if (href_rise) begin
                line_pix_q <= 16'(pix_wr_q);
            end else if (pix_wr_q && href_level) begin
                line_pix_q <= line_pix_q + 16'd1;
            end
            if (state_q == StIdle && start && !stop) begin
                err_line_q <= 1'b0;
            end else if (state_q == StCapture && href_fall && line_pix_q != 16'(H_PIX)) begin
                err_line_q <= 1'b1;
            end
        end
    end

    assign err_line = err_line_q;
`else
    logic unused_href;
    assign unused_href = href_level ^ href_rise;
`endif

    assign pix_en    = pix_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign err_ovf   = err_ovf_q;
    assign err_short = err_short_q;
    assign line_cnt  = line_cnt_q;

endmodule
